// File: rtl/uart_tx.sv
// 8N1 UART transmitter for the tiny16 console path.
// Bytes from the OUT strobe are queued in a small FIFO and sent LSB first.
module uart_tx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_en,
    input  logic [7:0] in,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            baud_done;
    logic            push;
    logic            pop;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign baud_done = (baud_cnt == 16'(CLKS_PER_BIT - 1));
    assign push      = in_en & ~full;
    // The FSM only takes a byte when idle or right at the end of a stop bit.
    assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
    assign busy      = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_en & full) begin
                overflow <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when data waits.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame vector table, corner sequences and a
// cycle-level reference model driven by random writes.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_en(in_en),
        .in(din),
        .tx(tx),
        .busy(busy),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] m_q[$];
    int         m_pos = -1;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;
    int         m_old;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
        end else begin
            m_old = m_q.size();
            if ((m_pos < 0 || m_pos == FRAME - 1) && m_old > 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end else if (m_pos == FRAME - 1) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
            if (in_en) begin
                if (m_old == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(din);
            end
        end
    end

    function automatic logic m_tx();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cycle_model", {27'd0, tx, busy, full, empty, overflow},
                  {27'd0, m_tx(), (m_pos >= 0) || (m_q.size() > 0),
                   m_q.size() == DEPTH, m_q.size() == 0, m_ovf});
        end
    end

    // Line receiver sampling each bit one cycle into its window.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_byte = 8'h00;
    int         rx_cnt = 0;
    int         rx_stop_err = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx === 1'b0) rx_cnt = 1;
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 2) % 4 == 0)
                rx_byte[(rx_cnt - 2) / 4 - 1] = tx;
            if (rx_cnt == 38) begin
                if (tx !== 1'b1) rx_stop_err++;
                rx_q.push_back(rx_byte);
            end
            if (rx_cnt == FRAME) rx_cnt = 0;
        end
    end

    task automatic check_rx();
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check("rx_byte", rx_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h01, 10'b1_00000001_0};
        vecs[5] = '{8'h80, 10'b1_10000000_0};

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        #2 rst = 1'b0;

        repeat (100) @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);

        foreach (vecs[v]) begin
            in_en = 1'b1;
            din = vecs[v].data;
            @(negedge clk);
            in_en = 1'b0;
            for (int b = 0; b < 10; b++) begin
                repeat (b == 0 ? 2 : CPB) @(negedge clk);
                check($sformatf("frame_%0h_bit%0d", vecs[v].data, b),
                      tx, vecs[v].frame[b]);
            end
            repeat (2) @(negedge clk);
            check("busy_last_stop", busy, 1'b1);
            @(negedge clk);
            check("busy_done", busy, 1'b0);
            repeat (3) @(negedge clk);
        end

        rx_q.delete();
        for (int i = 1; i <= 5; i++) begin
            in_en = 1'b1;
            din = 8'(i);
            @(negedge clk);
        end
        in_en = 1'b0;
        check("burst_full", full, 1'b1);
        check("burst_ovf", overflow, 1'b0);
        wait_idle(6 * FRAME);
        check("burst_empty", empty, 1'b1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx();

        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            in_en = 1'b1;
            din = 8'h11 + 8'(i);
            @(negedge clk);
        end
        in_en = 1'b0;
        check("ovf_pre_full", full, 1'b1);
        repeat (36) @(negedge clk);
        in_en = 1'b1;
        din = 8'h66;
        @(negedge clk);
        in_en = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_count3", full, 1'b0);
        check("ovf_busy", busy, 1'b1);
        wait_idle(6 * FRAME);
        check("ovf_sticky", overflow, 1'b1);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_rx();

        rx_q.delete();
        foreach (exp_q[i]) exp_q[i] = 8'h00;
        din = 8'h3C;
        in_en = 1'b1;
        @(negedge clk);
        din = 8'hAA;
        @(negedge clk);
        din = 8'h55;
        @(negedge clk);
        in_en = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_frame_bit3", tx, 1'b1);
        check("mid_frame_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_tx", tx, 1'b1);
        check("arst_empty", empty, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_frames", rx_q.size(), 0);
        check("post_rst_busy", busy, 1'b0);

        rx_q.delete();
        din = 8'h00;
        in_en = 1'b1;
        @(negedge clk);
        din = 8'hFF;
        @(negedge clk);
        in_en = 1'b0;
        wait_idle(3 * FRAME);
        exp_q = '{8'h00, 8'hFF};
        check_rx();

        for (int c = 0; c < 600; c++) begin
            in_en = ($urandom_range(0, 15) < 3);
            din = 8'($urandom);
            @(negedge clk);
        end
        in_en = 1'b0;
        wait_idle(6 * FRAME);
        check("stop_bits", rx_stop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
